stage_2: RTL and testbench

- Decode stage of the RV32I pipeline. It sits directly downstream of the if_id pipe register and consumes its pc and instr.
- Holds the 32x32 register file and generates immediates and control signals. Owns the id_ex pipeline register.
- Detects load-use hazards, and raises stall back to stage_1 and if_id.

---
 rtl/stage_2.sv | 132 +++++++++++++
 tb/tb_stage_2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stage_2.sv
// stage_2: RV32I decode stage with register file, load-use stall and id_ex pipeline register
module stage_2 #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] i_pc,
   input  logic [31:0]     i_instr,
   input  logic            b_taken,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall,
   output logic            id_ex_valid,
   output logic [XLEN-1:0] id_ex_pc,
   output logic [XLEN-1:0] id_ex_rs1_val,
   output logic [XLEN-1:0] id_ex_rs2_val,
   output logic [XLEN-1:0] id_ex_imm,
   output logic [4:0]      id_ex_rs1,
   output logic [4:0]      id_ex_rs2,
   output logic [4:0]      id_ex_rd,
   output logic [2:0]      id_ex_funct3,
   output logic            id_ex_alt,
   output logic            id_ex_reg_write,
   output logic            id_ex_mem_read,
   output logic            id_ex_mem_write,
   output logic            id_ex_branch,
   output logic            id_ex_jump,
   output logic            id_ex_alu_src,
   output logic            id_ex_illegal
);
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            alt;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            alu_src;
      logic            illegal;
   } id_ex_t;
   logic [XLEN-1:0] rf_q [NREGS];
   id_ex_t          ex_q, ex_d, dec;
   logic [6:0]      opc;
   logic [4:0]      rs1, rs2;
   logic            is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
   logic            fmt_i, use_rs1, use_rs2, hazard;
   assign opc       = i_instr[6:0];
   assign rs1       = i_instr[19:15];
   assign rs2       = i_instr[24:20];
   assign is_lui    = opc == OP_LUI;
   assign is_auipc  = opc == OP_AUIPC;
   assign is_jal    = opc == OP_JAL;
   assign is_jalr   = opc == OP_JALR;
   assign is_branch = opc == OP_BRANCH;
   assign is_load   = opc == OP_LOAD;
   assign is_store  = opc == OP_STORE;
   assign is_opimm  = opc == OP_IMM;
   assign is_op     = opc == OP_OP;
   assign fmt_i     = is_jalr || is_load || is_opimm;
   assign use_rs1   = fmt_i || is_branch || is_store || is_op;
   assign use_rs2   = is_branch || is_store || is_op;
   assign hazard    = ex_q.valid && ex_q.mem_read && ex_q.rd != 5'd0 &&
                      ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
   assign stall     = hazard && !b_taken;
   // combinational decode of the instruction sitting in if_id, with writeback bypass on reads
   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.pc        = i_pc;
      dec.rs1       = rs1;
      dec.rs2       = rs2;
      dec.rd        = i_instr[11:7];
      dec.funct3    = i_instr[14:12];
      dec.rs1_val   = (rs1 == 5'd0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
      dec.rs2_val   = (rs2 == 5'd0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];
      dec.imm       = fmt_i            ? {{20{i_instr[31]}}, i_instr[31:20]} :
                      is_store         ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
                      is_branch        ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                      is_lui || is_auipc ? {i_instr[31:12], 12'b0} :
                      is_jal           ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                      '0;
      dec.alt       = (is_op || (is_opimm && i_instr[14:12] == 3'b101)) ? i_instr[30] : 1'b0;
      dec.reg_write = is_lui || is_auipc || is_jal || fmt_i || is_op;
      dec.mem_read  = is_load;
      dec.mem_write = is_store;
      dec.branch    = is_branch;
      dec.jump      = is_jal || is_jalr;
      dec.alu_src   = is_lui || is_auipc || is_jal || fmt_i || is_store;
      dec.illegal   = !(use_rs1 || is_lui || is_auipc || is_jal);
   end
   assign ex_d = (b_taken || stall || i_instr == 32'b0) ? '0 : dec;
   // id_ex pipeline register; flush, stall and the if_id reset bubble all load zeros
   always_ff @(posedge clk) begin
      ex_q <= rst ? '0 : ex_d;
   end
   // register file write port; x0 is never written so it stays zero
   always_ff @(posedge clk) begin
      if (rst) rf_q <= '{default: '0};
      else if (wb_we && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
   end
   assign id_ex_valid     = ex_q.valid;
   assign id_ex_pc        = ex_q.pc;
   assign id_ex_rs1_val   = ex_q.rs1_val;
   assign id_ex_rs2_val   = ex_q.rs2_val;
   assign id_ex_imm       = ex_q.imm;
   assign id_ex_rs1       = ex_q.rs1;
   assign id_ex_rs2       = ex_q.rs2;
   assign id_ex_rd        = ex_q.rd;
   assign id_ex_funct3    = ex_q.funct3;
   assign id_ex_alt       = ex_q.alt;
   assign id_ex_reg_write = ex_q.reg_write;
   assign id_ex_mem_read  = ex_q.mem_read;
   assign id_ex_mem_write = ex_q.mem_write;
   assign id_ex_branch    = ex_q.branch;
   assign id_ex_jump      = ex_q.jump;
   assign id_ex_alu_src   = ex_q.alu_src;
   assign id_ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_stage_2.sv
// tb_stage_2: directed and randomized checks of stage_2 against an instruction-level decode model
module tb_stage_2;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        alt;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      logic        illegal;
   } ex_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_pc = '0, i_instr = '0, wb_data = '0;
   logic        b_taken = 1'b0, wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        stall, id_ex_valid, id_ex_alt, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
   logic        id_ex_branch, id_ex_jump, id_ex_alu_src, id_ex_illegal;
   logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
   logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [2:0]  id_ex_funct3;
   ex_t         got;
   ex_t         exp_q = '0;
   logic [31:0] mregs [32];
   logic        exp_stall, got_stall;
   int          n_checks = 0, n_fail = 0;
   always #5 clk = ~clk;
   stage_2 dut (
      .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .b_taken(b_taken),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
      .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1_val(id_ex_rs1_val),
      .id_ex_rs2_val(id_ex_rs2_val), .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1),
      .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_funct3(id_ex_funct3),
      .id_ex_alt(id_ex_alt), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_mem_write(id_ex_mem_write), .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
      .id_ex_alu_src(id_ex_alu_src), .id_ex_illegal(id_ex_illegal)
   );
   always_comb got = {id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm, id_ex_rs1,
                      id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_alt, id_ex_reg_write, id_ex_mem_read,
                      id_ex_mem_write, id_ex_branch, id_ex_jump, id_ex_alu_src, id_ex_illegal};
   function automatic logic uses1(input logic [31:0] ins);
      return ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction
   function automatic logic uses2(input logic [31:0] ins);
      return ins[6:0] inside {7'h63, 7'h23, 7'h33};
   endfunction
   function automatic logic [31:0] rdm(input logic [4:0] a, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && wr == a) return wd;
      return mregs[a];
   endfunction
   // instruction-set view of decode: format chosen per opcode, immediates by signed arithmetic
   function automatic ex_t decode(input logic [31:0] ins, input logic [31:0] p);
      ex_t e = '0;
      logic signed [11:0] ii = ins[31:20];
      logic signed [11:0] si = {ins[31:25], ins[11:7]};
      logic signed [12:0] bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      logic signed [20:0] ji = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      e.valid = 1'b1; e.pc = p; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.funct3 = ins[14:12];
      case (ins[6:0])
         7'h37, 7'h17: begin e.imm = ins[31:12] * 32'd4096; e.reg_write = 1; e.alu_src = 1; end
         7'h6F: begin e.imm = 32'(ji); e.reg_write = 1; e.jump = 1; e.alu_src = 1; end
         7'h67: begin e.imm = 32'(ii); e.reg_write = 1; e.jump = 1; e.alu_src = 1; end
         7'h63: begin e.imm = 32'(bi); e.branch = 1; end
         7'h03: begin e.imm = 32'(ii); e.reg_write = 1; e.mem_read = 1; e.alu_src = 1; end
         7'h23: begin e.imm = 32'(si); e.mem_write = 1; e.alu_src = 1; end
         7'h13: begin e.imm = 32'(ii); e.reg_write = 1; e.alu_src = 1; e.alt = (ins[14:12] == 3'd5) && ins[30]; end
         7'h33: begin e.reg_write = 1; e.alt = ins[30]; end
         default: e.illegal = 1;
      endcase
      return e;
   endfunction
   task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] p, input logic bt,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
      ex_t nxt;
      rst = r; i_instr = ins; i_pc = p; b_taken = bt; wb_we = we; wb_rd = wr; wb_data = wd;
      #2;
      got_stall = stall;
      exp_stall = exp_q.valid && exp_q.mem_read && exp_q.rd != 0 && !bt &&
                  ((uses1(ins) && ins[19:15] == exp_q.rd) || (uses2(ins) && ins[24:20] == exp_q.rd));
      nxt = decode(ins, p);
      nxt.rs1_val = rdm(ins[19:15], we, wr, wd);
      nxt.rs2_val = rdm(ins[24:20], we, wr, wd);
      if (r || bt || exp_stall || ins == 0) nxt = '0;
      @(posedge clk);
      exp_q = nxt;
      if (r) foreach (mregs[i]) mregs[i] = 0;
      else if (we && wr != 0) mregs[wr] = wd;
      #1;
   endtask
   task automatic test_reset;
      cycle(1, 32'h0050_0093, 32'h40, 0, 1, 5'd5, 32'h1234);
      n_checks++; if (got !== '0) begin n_fail++; $display("FAIL reset_first got %h want 0", got); end
      cycle(1, 32'h0050_0093, 32'h44, 0, 0, 0, 0);
      n_checks++; if (got !== '0) begin n_fail++; $display("FAIL reset_held got %h want 0", got); end
      cycle(0, 32'h0000_0000, 0, 0, 1, 5'd5, 32'h1234);
      cycle(1, 32'h0000_0000, 0, 0, 1, 5'd5, 32'h5678);
      cycle(0, 32'h0002_8433, 32'h8, 0, 0, 0, 0);
      n_checks++; if (id_ex_rs1_val !== 32'd0) begin n_fail++; $display("FAIL reset_clears_x5 got %h want 0", id_ex_rs1_val); end
   endtask
   task automatic test_addi;
      cycle(0, 32'h0050_0093, 32'h10, 0, 0, 0, 0);
      n_checks++; if (id_ex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", id_ex_valid); end
      n_checks++; if (id_ex_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd got %0d want 1", id_ex_rd); end
      n_checks++; if (id_ex_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %h want 5", id_ex_imm); end
      n_checks++; if ({id_ex_reg_write, id_ex_alu_src} !== 2'b11) begin n_fail++; $display("FAIL addi_ctl got %b want 11", {id_ex_reg_write, id_ex_alu_src}); end
      n_checks++; if (id_ex_rs1_val !== 32'd0) begin n_fail++; $display("FAIL addi_rs1_val got %h want 0", id_ex_rs1_val); end
      n_checks++; if (id_ex_pc !== 32'h10) begin n_fail++; $display("FAIL addi_pc got %h want 10", id_ex_pc); end
      n_checks++; if (got !== exp_q) begin n_fail++; $display("FAIL addi_all got %h want %h", got, exp_q); end
   endtask
   task automatic test_writethrough;
      cycle(0, 32'h0021_01B3, 32'h14, 0, 1, 5'd2, 32'hDEAD_BEEF);
      n_checks++; if ({id_ex_rs1_val, id_ex_rs2_val} !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL wt_bypass got %h %h want deadbeef", id_ex_rs1_val, id_ex_rs2_val); end
      cycle(0, 32'h0001_0233, 32'h18, 0, 0, 0, 0);
      n_checks++; if (id_ex_rs1_val !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wt_later got %h want deadbeef", id_ex_rs1_val); end
   endtask
   task automatic test_load_use;
      cycle(0, 32'h0000_A283, 32'h20, 0, 0, 0, 0);
      n_checks++; if (id_ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL lu_load got %b want 1", id_ex_mem_read); end
      cycle(0, 32'h0002_8333, 32'h24, 0, 0, 0, 0);
      n_checks++; if (got_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", got_stall); end
      n_checks++; if (got !== '0) begin n_fail++; $display("FAIL lu_bubble got %h want 0", got); end
      cycle(0, 32'h0002_8333, 32'h24, 0, 0, 0, 0);
      n_checks++; if (got_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b want 0", got_stall); end
      n_checks++; if ({id_ex_valid, id_ex_rd} !== {1'b1, 5'd6}) begin n_fail++; $display("FAIL lu_redecode got %b/%0d want 1/6", id_ex_valid, id_ex_rd); end
   endtask
   task automatic test_no_hazard;
      cycle(0, 32'h0000_A283, 32'h30, 0, 0, 0, 0);
      cycle(0, 32'h0010_0313, 32'h34, 0, 0, 0, 0);
      n_checks++; if (got_stall !== 1'b0) begin n_fail++; $display("FAIL nh_unused_rs got %b want 0", got_stall); end
      cycle(0, 32'h0000_A003, 32'h38, 0, 0, 0, 0);
      cycle(0, 32'h0000_0333, 32'h3C, 0, 0, 0, 0);
      n_checks++; if (got_stall !== 1'b0) begin n_fail++; $display("FAIL nh_rd_zero got %b want 0", got_stall); end
      n_checks++; if (id_ex_valid !== 1'b1) begin n_fail++; $display("FAIL nh_valid got %b want 1", id_ex_valid); end
   endtask
   task automatic test_flush;
      cycle(0, 32'h0000_A283, 32'h40, 0, 0, 0, 0);
      cycle(0, 32'h0002_8333, 32'h44, 1, 1, 5'd0, 32'd7);
      n_checks++; if (got_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall got %b want 0", got_stall); end
      n_checks++; if (got !== '0) begin n_fail++; $display("FAIL fl_bubble got %h want 0", got); end
      cycle(0, 32'h0000_03B3, 32'h48, 0, 0, 0, 0);
      n_checks++; if (id_ex_rs1_val !== 32'd0) begin n_fail++; $display("FAIL fl_x0 got %h want 0", id_ex_rs1_val); end
   endtask
   task automatic test_branch_jump;
      cycle(0, 32'hFE00_0EE3, 32'h50, 0, 0, 0, 0);
      n_checks++; if (id_ex_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL beq_imm got %h want fffffffc", id_ex_imm); end
      n_checks++; if ({id_ex_branch, id_ex_reg_write} !== 2'b10) begin n_fail++; $display("FAIL beq_ctl got %b want 10", {id_ex_branch, id_ex_reg_write}); end
      cycle(0, 32'h0010_00EF, 32'h54, 0, 0, 0, 0);
      n_checks++; if ({id_ex_imm, id_ex_jump} !== {32'h800, 1'b1}) begin n_fail++; $display("FAIL jal got %h/%b want 800/1", id_ex_imm, id_ex_jump); end
      cycle(0, 32'h0000_007F, 32'h58, 0, 0, 0, 0);
      n_checks++; if ({id_ex_illegal, id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jump} !== 7'b1100000) begin
         n_fail++; $display("FAIL illegal got %b want 1100000", {id_ex_illegal, id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jump}); end
      cycle(0, 32'h0000_0000, 32'h5C, 0, 0, 0, 0);
      n_checks++; if (got !== '0) begin n_fail++; $display("FAIL zero_instr got %h want 0", got); end
   endtask
   task automatic test_random;
      logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};
      logic [31:0] ins;
      int          stalls = 0;
      for (int n = 0; n < 600; n++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 3) == 0) ins[6:0] = 7'h03;
         ins[11:7] = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) ins = 0;
         cycle($urandom_range(0, 49) == 0, ins, $urandom, $urandom_range(0, 9) == 0,
               1'($urandom), 5'($urandom_range(0, 7)), $urandom);
         if (exp_stall) stalls++;
         n_checks++; if (got_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b want %b", n, got_stall, exp_stall); end
         n_checks++; if (got !== exp_q) begin n_fail++; $display("FAIL rnd_idex cyc %0d got %h want %h", n, got, exp_q); end
      end
      n_checks++; if (stalls == 0) begin n_fail++; $display("FAIL rnd_coverage got 0 stalls want >0"); end
   endtask
   initial begin
      foreach (mregs[i]) mregs[i] = 0;
      test_reset;
      test_addi;
      test_writethrough;
      test_load_use;
      test_no_hazard;
      test_flush;
      test_branch_jump;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
